// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the bit-serial ALU sequencer.
//   - ALUcontrol op codes (ALU_AND .. ALU_SLT)
//   - state_t: sequencer FSM states {IDLE, RUN, DONE}
//   - cin_of():   carry-in of bit 0 for a given op (1 for SUB/SLT)
//   - is_arith(): op uses the adder carry chain (ADD/SUB/SLT)
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NAND = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Subtract-style ops form A + ~B + 1, so they start with carry set.
    function automatic logic cin_of(input logic [2:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_serial_bit.sv
// alu_serial_bit: combinational 1-bit ALU slice.
// Ports:
//   i_a, i_b   operand bits
//   i_cin      carry into this bit
//   i_add_sub  1 = invert B (subtract), 0 = add
//   i_op       ALUcontrol op code
//   o_res      logic/sum result bit for i_op (0 for SLT; the sequencer builds SLT)
//   o_set      raw adder sum bit (used as the SLT "set" at the MSB)
//   o_cout     adder carry out
module alu_serial_bit
    import alu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_cin,
    input  logic       i_add_sub,
    input  logic [2:0] i_op,
    output logic       o_res,
    output logic       o_set,
    output logic       o_cout
);

    logic w_b_eff;
    logic w_sum;

    assign w_b_eff = i_b ^ i_add_sub;
    assign w_sum   = i_a ^ w_b_eff ^ i_cin;
    assign o_set   = w_sum;
    assign o_cout  = (i_a & w_b_eff) | (i_cin & (i_a ^ w_b_eff));

    always_comb begin
        o_res = 1'b0;
        case (i_op)
            ALU_AND:  o_res = i_a & i_b;
            ALU_OR:   o_res = i_a | i_b;
            ALU_ADD:  o_res = w_sum;
            ALU_NOR:  o_res = ~(i_a | i_b);
            ALU_XOR:  o_res = i_a ^ i_b;
            ALU_NAND: o_res = ~(i_a & i_b);
            ALU_SUB:  o_res = w_sum;
            default:  o_res = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer. Latches op/SrcA/SrcB on accept, then runs one
// alu_serial_bit slice LSB->MSB, one bit per clock, chaining the carry through a register.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   start       request, accepted only while ready=1
//   ALUcontrol  op code, sampled on accept
//   SrcA, SrcB  WIDTH-bit operands, sampled on accept
//   ready       1 in IDLE only
//   done        one-cycle pulse, result outputs valid
//   ALUresult   result, held until next accept completes
//   zero        ALUresult == 0
//   cout        final adder carry (0 for logic ops)
//   ovf         signed overflow, only when ALU_SERIAL_OVF_EN is defined
// Build option: ALU_SERIAL_OVF_EN adds the ovf port and makes SLT signed-correct.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUcontrol,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] ALUresult,
    output logic             zero,
    output logic             cout
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic             w_bit_res;
    logic             w_bit_set;
    logic             w_bit_cout;
    logic             w_arith;
    logic             w_slt_bit;
    logic [WIDTH-1:0] w_final;

    alu_serial_bit u_bit (
        .i_a       (r_a[0]),
        .i_b       (r_b[0]),
        .i_cin     (r_carry),
        .i_add_sub (cin_of(r_op)),
        .i_op      (r_op),
        .o_res     (w_bit_res),
        .o_set     (w_bit_set),
        .o_cout    (w_bit_cout)
    );

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_BIT);
    assign w_arith  = is_arith(r_op);

`ifdef ALU_SERIAL_OVF_EN
    logic r_ovf;
    logic w_ovf;
    // At the MSB, r_carry is the carry into the MSB and w_bit_cout the carry out of it.
    assign w_ovf     = w_arith && (r_carry ^ w_bit_cout);
    assign w_slt_bit = w_bit_set ^ w_ovf;
    assign ovf       = r_ovf;
`else
    assign w_slt_bit = w_bit_set;
`endif

    // Final result as it stands once the MSB slice output is shifted in.
    assign w_final = (r_op == ALU_SLT) ? {{(WIDTH-1){1'b0}}, w_slt_bit}
                                       : {w_bit_res, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (r_cnt == LAST_BIT) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op     <= ALU_AND;
            r_a      <= '0;
            r_b      <= '0;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cout   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_op    <= ALUcontrol;
            r_a     <= SrcA;
            r_b     <= SrcB;
            r_cnt   <= '0;
            r_carry <= cin_of(ALUcontrol);
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_shift <= {w_bit_res, r_shift[WIDTH-1:1]};
            r_carry <= w_bit_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_result <= w_final;
                r_zero   <= (w_final == '0);
                r_cout   <= w_arith && w_bit_cout;
`ifdef ALU_SERIAL_OVF_EN
                r_ovf    <= w_ovf;
`endif
            end
        end
    end

    assign ready     = (r_state == IDLE);
    assign done      = (r_state == DONE);
    assign ALUresult = r_result;
    assign zero      = r_zero;
    assign cout      = r_cout;

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed, table-driven bench for alu_serial_seq (WIDTH=32),
// plus hand sequences for ignored start pulses and mid-operation reset.
module tb_alu_serial_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   ALUcontrol;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         ready;
    logic         done;
    logic [W-1:0] ALUresult;
    logic         zero;
    logic         cout;
`ifdef ALU_SERIAL_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ALUcontrol (ALUcontrol),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ready      (ready),
        .done       (done),
        .ALUresult  (ALUresult),
        .zero       (zero),
        .cout       (cout)
`ifdef ALU_SERIAL_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[13];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op; returns number of rising edges from the accept edge (counted as 1) until
    // done is seen high. Operands are scrambled after accept.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int edges);
        @(negedge clk);
        ALUcontrol = op;
        SrcA       = a;
        SrcB       = b;
        start      = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        SrcA  = ~a;
        SrcB  = a ^ b;
        while (!done && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int edges;
        check({v.name, " ready"}, W'(ready), W'(1));
        run_op(v.op, v.a, v.b, edges);
        check({v.name, " latency"}, W'(edges), W'(W + 1));
        check({v.name, " result"}, ALUresult, v.res);
        check({v.name, " zero"}, W'(zero), W'(v.zero));
        check({v.name, " cout"}, W'(cout), W'(v.cout));
`ifdef ALU_SERIAL_OVF_EN
        check({v.name, " ovf"}, W'(ovf), W'(v.ovf));
`endif
        @(negedge clk);
        check({v.name, " done pulse"}, W'(done), W'(0));
    endtask

    initial begin
        int edges;
        int dones;
        int done_edge;

        vecs[0]  = '{"add_wrap",  ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0};
        vecs[1]  = '{"sub_5_7",   ALU_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0, 0};
        vecs[2]  = '{"sub_7_7",   ALU_SUB,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1, 1, 0};
        vecs[3]  = '{"slt_m1_1",  ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 1, 0};
        vecs[4]  = '{"slt_3_2",   ALU_SLT,  32'h0000_0003, 32'h0000_0002, 32'h0000_0000, 1, 1, 0};
        vecs[5]  = '{"nor",       ALU_NOR,  32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 0, 0, 0};
        vecs[6]  = '{"nand_ones", ALU_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0};
        vecs[7]  = '{"and",       ALU_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0, 0, 0};
        vecs[8]  = '{"or",        ALU_OR,   32'h1200_0000, 32'h0034_0056, 32'h1234_0056, 0, 0, 0};
        vecs[9]  = '{"xor",       ALU_XOR,  32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 0, 0, 0};
        vecs[10] = '{"add_plain", ALU_ADD,  32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0, 0, 0};
        vecs[11] = '{"add_msb",   ALU_ADD,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1, 1};
`ifdef ALU_SERIAL_OVF_EN
        vecs[12] = '{"slt_min_1", ALU_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 0, 1, 1};
`else
        vecs[12] = '{"slt_min_1", ALU_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1, 1, 1};
`endif

        reset      = 1'b0;
        start      = 1'b0;
        ALUcontrol = ALU_AND;
        SrcA       = '0;
        SrcB       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", W'(ready), W'(1));
        check("reset done", W'(done), W'(0));
        check("reset result", ALUresult, '0);
        check("reset zero", W'(zero), W'(0));
        check("reset cout", W'(cout), W'(0));
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

        // Start pulses during RUN and DONE must be ignored.
        @(negedge clk);
        ALUcontrol = ALU_ADD;
        SrcA       = 32'h0000_0010;
        SrcB       = 32'h0000_0020;
        start      = 1'b1;
        @(posedge clk);
        edges     = 1;
        dones     = 0;
        done_edge = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                done_edge = edges;
            end
            start      = (edges == 5) || (edges == 33);
            ALUcontrol = ALU_SUB;
            SrcA       = 32'hDEAD_BEEF;
            SrcB       = 32'h1234_5678;
            @(posedge clk);
            edges++;
        end
        @(negedge clk);
        start = 1'b0;
        check("ignore single done", W'(dones), W'(1));
        check("ignore done cycle", W'(done_edge), W'(W + 1));
        check("ignore result", ALUresult, 32'h0000_0030);
        check("ignore ready", W'(ready), W'(1));

        // Reset during RUN aborts the op with no done pulse.
        ALUcontrol = ALU_ADD;
        SrcA       = 32'h0000_0005;
        SrcB       = 32'h0000_0006;
        start      = 1'b1;
        @(posedge clk);
        edges = 1;
        dones = 0;
        @(negedge clk);
        start = 1'b0;
        while (edges < 10) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) dones++;
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("abort ready", W'(ready), W'(1));
        check("abort result", ALUresult, '0);
        check("abort done", W'(done), W'(0));
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no done", W'(dones), W'(0));
        run_vec('{"after_abort", ALU_ADD, 32'h0000_0005, 32'h0000_0006, 32'h0000_000B, 0, 0, 0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
